// File: rtl/baseline_tracking_selftrigger.sv
// Per-channel pedestal tracker (freezable EMA) with saturating subtraction and a
// threshold/hysteresis/holdoff self-trigger.
module baseline_tracking_selftrigger #(
  parameter int unsigned NCH         = 40,
  parameter int unsigned DW          = 16,
  parameter int unsigned BL_SHIFT    = 6,
  parameter int unsigned HYST        = 16,
  parameter int unsigned HOLDOFF_LEN = 256
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 enable,
  input  logic [NCH-1:0]       ch_mask,
  input  logic signed [DW-1:0] threshold,
  input  logic [1:0]           output_selector,
  input  logic [NCH*DW-1:0]    x,
  output logic [NCH*DW-1:0]    y,
  output logic [NCH-1:0]       trigger_output
);

  localparam int unsigned AW = DW + BL_SHIFT + 1;
  localparam int unsigned CW = $clog2(HOLDOFF_LEN) + 1;
  localparam logic [CW-1:0] CntLast = CW'(HOLDOFF_LEN - 1);
  localparam logic [DW:0]   HystW   = (DW + 1)'(HYST);
  localparam logic [DW-1:0] SatMax  = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0] SatMin  = {1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StActive, StHoldoff} state_e;

  logic signed [DW:0] w_thr_lo;
  assign w_thr_lo = {threshold[DW-1], threshold} - HystW;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0]        w_x;
    logic [DW-1:0]        w_bl;
    logic [DW:0]          w_diff;
    logic [DW-1:0]        w_sat;
    logic                 w_act;
    logic                 w_valid;
    logic                 w_above;
    logic                 w_below;
    logic                 w_trig;
    logic [DW-1:0]        r_x;
    logic signed [DW-1:0] r_d;
    logic [DW-1:0]        r_y;
    logic signed [AW-1:0] r_acc;
    logic                 r_init;
    logic                 r_dv;
    logic                 r_trig;
    logic [CW-1:0]        r_cnt;
    state_e               r_state;

    assign w_x    = x[c*DW +: DW];
    assign w_act  = enable & ch_mask[c];
    assign w_bl   = r_acc[BL_SHIFT +: DW];
    assign w_diff = {w_x[DW-1], w_x} - {w_bl[DW-1], w_bl};
    // Overflow out of DW bits shows up as the two top bits disagreeing.
    assign w_sat  = (w_diff[DW] != w_diff[DW-1]) ? (w_diff[DW] ? SatMin : SatMax)
                                                 : w_diff[DW-1:0];

    // r_dv marks d_r as computed from an initialised baseline; the init cycle's
    // d_r is taken against the stale baseline and must not feed the FSM or EMA.
    assign w_valid = w_act & r_init & r_dv;
    assign w_above = r_d >= threshold;
    assign w_below = $signed({r_d[DW-1], r_d}) < w_thr_lo;
    assign w_trig  = w_valid & (r_state == StIdle) & w_above;

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        r_x     <= '0;
        r_d     <= '0;
        r_y     <= '0;
        r_acc   <= '0;
        r_init  <= 1'b0;
        r_dv    <= 1'b0;
        r_trig  <= 1'b0;
        r_cnt   <= '0;
        r_state <= StIdle;
      end else begin
        r_x  <= w_x;
        r_d  <= w_sat;
        r_dv <= w_act & r_init;

        if (!w_act) begin
          r_init <= 1'b0;
        end else if (!r_init) begin
          r_init <= 1'b1;
          r_acc  <= {{(BL_SHIFT + 1){w_x[DW-1]}}, w_x} << BL_SHIFT;
        end else if (r_dv && (r_state == StIdle) && !w_above) begin
          r_acc <= r_acc + {{(BL_SHIFT + 1){r_d[DW-1]}}, r_d};
        end

        if (!w_valid) begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end else begin
          unique case (r_state)
            StIdle: begin
              if (w_above) r_state <= StActive;
            end
            StActive: begin
              if (w_below) begin
                r_state <= StHoldoff;
                r_cnt   <= '0;
              end
            end
            StHoldoff: begin
              if (w_above) begin
                r_state <= StActive;
              end else if (r_cnt == CntLast) begin
                r_state <= StIdle;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            default: r_state <= StIdle;
          endcase
        end

        if (!w_act) begin
          r_y <= r_x;
        end else begin
          case (output_selector)
            2'b01:   r_y <= w_bl;
            2'b10:   r_y <= r_x;
            default: r_y <= r_d;
          endcase
        end
        r_trig <= w_trig;
      end
    end

    assign y[c*DW +: DW] = r_y;
    assign trigger_output[c] = r_trig;
  end

endmodule

// File: tb/tb_baseline_tracking_selftrigger.sv
// Directed bench for baseline_tracking_selftrigger: vector table plus pulse,
// holdoff, saturation and mid-pulse reset sequences.
module tb_baseline_tracking_selftrigger;

  localparam int NCH = 40;
  localparam int DW  = 16;
  localparam int NV  = 19;
  localparam int NONE = -10000;

  logic                 clk = 1'b0;
  logic                 n_reset;
  logic                 enable;
  logic [NCH-1:0]       ch_mask;
  logic signed [DW-1:0] threshold;
  logic [1:0]           sel;
  logic [NCH*DW-1:0]    x;
  logic [NCH*DW-1:0]    y;
  logic [NCH-1:0]       trig;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic       m3;
    logic [1:0] sel;
    int         xv;
    int         x3;
    int         ey;
    int         ey3;
  } vec_t;

  vec_t tbl[NV];
  int   st[4];
  int   tr[4];

  baseline_tracking_selftrigger #(
    .NCH(NCH), .DW(DW), .BL_SHIFT(6), .HYST(16), .HOLDOFF_LEN(256)
  ) u_dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .enable         (enable),
    .ch_mask        (ch_mask),
    .threshold      (threshold),
    .output_selector(sel),
    .x              (x),
    .y              (y),
    .trigger_output (trig)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(int v);
    for (int c = 0; c < NCH; c++) x[c*DW +: DW] = DW'(v);
  endtask

  task automatic set_ch(int c, int v);
    x[c*DW +: DW] = DW'(v);
  endtask

  task automatic chk_y(string name, int c, int e);
    logic signed [DW-1:0] g;
    g = y[c*DW +: DW];
    n_cmp++;
    if (g !== DW'(e)) begin
      n_err++;
      $display("FAIL %s: y[ch%0d] got %0d, required %0d", name, c, g, e);
    end
  endtask

  task automatic chk_trig(string name, logic [NCH-1:0] e);
    n_cmp++;
    if (trig !== e) begin
      n_err++;
      $display("FAIL %s: trigger_output got %h, required %h", name, trig, e);
    end
  endtask

  function automatic bit in_win(int i, int s[4], int w);
    for (int k = 0; k < 4; k++) if (s[k] != NONE && i >= s[k] && i < s[k] + w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_list(int i, int s[4]);
    for (int k = 0; k < 4; k++) if (s[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  // 5-sample 600-count pulses on ch7 over a converged 8000 baseline.
  task automatic run_pulses(string tag, int ncyc, int s[4], int t[4], logic [1:0] osel);
    logic [NCH-1:0] et;
    sel = osel;
    for (int i = 0; i < ncyc; i++) begin
      set_ch(7, in_win(i, s, 5) ? 8600 : 8000);
      tick();
      et = '0;
      et[7] = in_list(i, t);
      chk_trig($sformatf("%s c%0d trig", tag, i), et);
      if (osel == 2'b01) chk_y($sformatf("%s c%0d baseline", tag, i), 7, 8000);
      else chk_y($sformatf("%s c%0d y", tag, i), 7, in_win(i - 1, s, 5) ? 600 : 0);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 2'd0,  8000,  8000,     0,     0};
    tbl[1]  = '{1'b1, 1'b1, 2'd0,  8000,  8000,  8000,  8000};
    tbl[2]  = '{1'b1, 1'b1, 2'd0,  8000,  8000,     0,     0};
    tbl[3]  = '{1'b1, 1'b1, 2'd0,  8000,  8000,     0,     0};
    tbl[4]  = '{1'b1, 1'b1, 2'd0,  8000,  8000,     0,     0};
    tbl[5]  = '{1'b1, 1'b1, 2'd1,  8000,  8000,  8000,  8000};
    tbl[6]  = '{1'b1, 1'b1, 2'd2,  8000,  8000,  8000,  8000};
    tbl[7]  = '{1'b1, 1'b1, 2'd3,  8000,  8000,     0,     0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0,  8000,  1234,     0,  8000};
    tbl[9]  = '{1'b1, 1'b0, 2'd0,  8000,    -5,     0,  1234};
    tbl[10] = '{1'b1, 1'b0, 2'd0,  8000,   777,     0,    -5};
    tbl[11] = '{1'b0, 1'b0, 2'd0,   100,   777,  8000,   777};
    tbl[12] = '{1'b0, 1'b0, 2'd0,  -200,    50,   100,   777};
    tbl[13] = '{1'b0, 1'b0, 2'd0,   300,   300,  -200,    50};
    tbl[14] = '{1'b1, 1'b1, 2'd1,   300,   300,  8000,  8000};
    tbl[15] = '{1'b1, 1'b1, 2'd1,   300,   300,   300,   300};
    tbl[16] = '{1'b1, 1'b1, 2'd0,   300,   300,     0,     0};
    tbl[17] = '{1'b1, 1'b1, 2'd0,   300,   300,     0,     0};
    tbl[18] = '{1'b1, 1'b1, 2'd0,   300,   300,     0,     0};

    n_reset   = 1'b0;
    enable    = 1'b1;
    ch_mask   = '1;
    threshold = 16'sd100;
    sel       = 2'b00;
    set_all(8000);
    #12;
    n_reset = 1'b1;
    n_cmp++;
    if (y !== '0) begin
      n_err++;
      $display("FAIL reset y: got %h, required 0", y);
    end
    chk_trig("reset trig", '0);

    for (int i = 0; i < NV; i++) begin
      int bad;
      int e;
      enable     = tbl[i].en;
      ch_mask    = '1;
      ch_mask[3] = tbl[i].m3;
      sel        = tbl[i].sel;
      set_all(tbl[i].xv);
      set_ch(3, tbl[i].x3);
      tick();
      bad = -1;
      for (int c = 0; c < NCH; c++) begin
        e = (c == 3) ? tbl[i].ey3 : tbl[i].ey;
        if (bad < 0 && y[c*DW +: DW] !== DW'(e)) bad = c;
      end
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        e = (bad == 3) ? tbl[i].ey3 : tbl[i].ey;
        $display("FAIL vec%0d y[ch%0d]: got %0d, required %0d", i, bad,
                 $signed(y[bad*DW +: DW]), e);
      end
      chk_trig($sformatf("vec%0d trig", i), '0);
    end

    // Re-seed every channel at 8000.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    set_all(8000);
    repeat (4) tick();

    st = '{0, 262, NONE, NONE};  tr = '{1, 263, NONE, NONE};
    run_pulses("holdoff_edge", 600, st, tr, 2'b00);
    st = '{0, 261, NONE, NONE};  tr = '{1, NONE, NONE, NONE};
    run_pulses("holdoff_in", 600, st, tr, 2'b00);
    st = '{0, 300, NONE, NONE};  tr = '{1, 301, NONE, NONE};
    run_pulses("gap300", 600, st, tr, 2'b00);
    st = '{0, 100, 300, 600};    tr = '{1, 601, NONE, NONE};
    run_pulses("restart", 620, st, tr, 2'b01);

    // Saturation on ch0 against a 30000 baseline.
    sel = 2'b00;
    ch_mask[0] = 1'b0;
    set_ch(0, 30000);
    tick();
    ch_mask[0] = 1'b1;
    repeat (4) tick();
    chk_y("sat settled", 0, 0);
    set_ch(0, -30000);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_y($sformatf("sat%0d", k), 0, -32768);
      chk_trig($sformatf("sat%0d trig", k), '0);
    end

    // Reset in the middle of a ch5 pulse.
    set_ch(5, 8600);
    tick();
    tick();
    chk_trig("rst pulse trig", 40'h1 << 5);
    chk_y("rst pulse y", 5, 600);
    tick();
    chk_trig("rst active trig", '0);
    #3;
    n_reset = 1'b0;
    #1;
    n_cmp++;
    if (y !== '0) begin
      n_err++;
      $display("FAIL async reset y: got %h, required 0", y);
    end
    chk_trig("async reset trig", '0);
    @(posedge clk);
    #2;
    n_reset = 1'b1;
    tick();
    chk_y("rel e1", 5, 0);
    tick();
    chk_y("rel e2", 5, 8600);
    chk_trig("rel e2 trig", '0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_y($sformatf("rel e%0d", k + 3), 5, 0);
      chk_trig($sformatf("rel e%0d trig", k + 3), '0);
    end
    sel = 2'b01;
    tick();
    chk_y("rel baseline", 5, 8600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
